// File: rtl/xm_mem_ctrl.sv
// xm_mem_ctrl: bridges single load/store requests from the control plane onto
// an external acknowledge-based memory bus, with byte lane steering and a
// bounded wait for the bus acknowledge.
module xm_mem_ctrl #(
    parameter int WORD    = 16,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            arst_i,
    input  logic            memEn_i,
    input  logic            memRW_i,
    input  logic            byteOp_i,
    input  logic [WORD-1:0] adr_i,
    input  logic [WORD-1:0] wrData_i,
    output logic            memBusy_o,
    output logic            memWr_o,
    output logic [WORD-1:0] rdData_o,
    output logic            busErr_o,
    output logic            busReq_o,
    output logic            busWe_o,
    output logic [WORD-2:0] busAdr_o,
    output logic [1:0]      busBe_o,
    output logic [WORD-1:0] busWdata_o,
    input  logic [WORD-1:0] busRdata_i,
    input  logic            busAck_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // Wait counter value on which the access is abandoned if still unacknowledged.
    localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

    state_t          state;
    state_t          next_state;
    logic            acc_we;
    logic            acc_byte;
    logic [WORD-1:0] acc_adr;
    logic [WORD-1:0] acc_wdata;
    logic [7:0]      wait_cnt;
    logic            read_ok;
    logic            timed_out;
    logic            in_req;
    logic            in_done;
    logic            give_up;
    logic [WORD-1:0] rd_capture;

    assign in_req  = (state == REQ);
    assign in_done = (state == DONE);
    assign give_up = (wait_cnt == LAST_WAIT);

    // Byte reads pick the lane selected by the low address bit and zero-extend it.
    always_comb begin
        rd_capture = busRdata_i;
        if (acc_byte) begin
            if (acc_adr[0]) begin
                rd_capture = {{(WORD-8){1'b0}}, busRdata_i[WORD-1:WORD-8]};
            end else begin
                rd_capture = {{(WORD-8){1'b0}}, busRdata_i[7:0]};
            end
        end
    end

    // State register; reset drops any access in flight straight back to IDLE.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: an ack always beats the timeout, and DONE lasts a single cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (memEn_i) begin
                    next_state = REQ;
                end
            end
            REQ: begin
                if (busAck_i || give_up) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request latching, wait counting, completion flags and read data capture.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            acc_we    <= 1'b0;
            acc_byte  <= 1'b0;
            acc_adr   <= '0;
            acc_wdata <= '0;
            wait_cnt  <= '0;
            read_ok   <= 1'b0;
            timed_out <= 1'b0;
            rdData_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (memEn_i) begin
                        acc_we    <= memRW_i;
                        acc_byte  <= byteOp_i;
                        acc_adr   <= adr_i;
                        acc_wdata <= wrData_i;
                        wait_cnt  <= '0;
                        read_ok   <= 1'b0;
                        timed_out <= 1'b0;
                    end
                end
                REQ: begin
                    if (busAck_i) begin
                        read_ok   <= ~acc_we;
                        timed_out <= 1'b0;
                        if (!acc_we) begin
                            rdData_o <= rd_capture;
                        end
                    end else if (give_up) begin
                        read_ok   <= 1'b0;
                        timed_out <= 1'b1;
                        rdData_o  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Bus outputs are only driven while the request is outstanding, so they are
    // zero in IDLE/DONE and vanish as soon as reset forces the state to IDLE.
    always_comb begin
        memBusy_o  = in_req;
        busReq_o   = in_req;
        busWe_o    = in_req & acc_we;
        busAdr_o   = '0;
        busBe_o    = 2'b00;
        busWdata_o = '0;
        memWr_o    = in_done & read_ok;
        busErr_o   = in_done & timed_out;
        if (in_req) begin
            busAdr_o = acc_adr[WORD-1:1];
            if (acc_byte) begin
                busBe_o    = acc_adr[0] ? 2'b10 : 2'b01;
                busWdata_o = {(WORD/8){acc_wdata[7:0]}};
            end else begin
                busBe_o    = 2'b11;
                busWdata_o = acc_wdata;
            end
        end
    end

endmodule
